// File: rtl/dsm_dac_if.sv
`default_nettype none
// ============================================================================
// Module      : dsm_dac_if
// Description : Sample-input handshake bundle for the delta-sigma DAC.
//               The producer (master) drives an offset-binary sample with a
//               valid strobe; the modulator (slave) answers with ready while
//               its one-entry buffer is empty.
// Revision    : 1.0 - initial release
// ============================================================================
interface dsm_dac_if #(
    parameter int IN_W = 16
) ();

    logic [IN_W-1:0] in_data;   // offset-binary sample
    logic            in_valid;  // in_data is valid
    logic            in_ready;  // buffer empty, sample accepted on valid&ready

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface
`default_nettype wire

// File: rtl/dsm_dac.sv
`default_nettype none
// ============================================================================
// Module      : dsm_dac
// Description : 1st/2nd-order error-feedback delta-sigma modulator for the
//               stimulator DAC path. Offset-binary PCM samples enter through a
//               one-entry valid/ready buffer, are consumed once every OSR
//               clocks, and are converted into a 1-bit density stream on
//               complementary outputs. Provides mute (en low), clamping of the
//               loop error with a sticky sat flag, and a sticky underrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dsm_dac #(
    parameter int IN_W  = 16,
    parameter int ORDER = 2,
    parameter int OSR   = 64,
    parameter int ACC_W = IN_W + 4
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          en,
    input  wire          flag_clr,
    dsm_dac_if.slave     in_if,
    output logic         outp,
    output logic         outn,
    output logic         sat,
    output logic         underrun
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = (OSR > 2) ? $clog2(OSR) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(OSR - 1);

    // Midscale of the offset-binary input: 2^(IN_W-1)
    localparam logic [IN_W-1:0] c_MID = {1'b1, {(IN_W-1){1'b0}}};

    // H = 2^(IN_W-1) in the signed loop width
    localparam logic signed [ACC_W-1:0] c_HALF =
        {{(ACC_W-IN_W){1'b0}}, 1'b1, {(IN_W-1){1'b0}}};

    // Error register range [-2H, 2H-1]
    localparam logic signed [ACC_W-1:0] c_POS_LIM =
        {{(ACC_W-IN_W){1'b0}}, {IN_W{1'b1}}};
    localparam logic signed [ACC_W-1:0] c_NEG_LIM =
        {{(ACC_W-IN_W){1'b1}}, {IN_W{1'b0}}};

    // ------------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------------
    generate
        if (OSR < 2) begin : g_bad_osr
            $error("dsm_dac: OSR must be at least 2");
        end
        if (ACC_W < IN_W + 2 * ORDER) begin : g_bad_acc_w
            $error("dsm_dac: ACC_W too narrow for the chosen ORDER");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [IN_W-1:0]         r_buf;       // one-entry input buffer
    logic                    r_buf_full;  // buffer holds an unconsumed sample
    logic [IN_W-1:0]         r_cur;       // sample currently being modulated
    logic [c_CNT_W-1:0]      r_cnt;       // oversampling divider
    logic signed [ACC_W-1:0] r_e1;        // most recent quantisation error
    logic                    r_outp;
    logic                    r_outn;
    logic                    r_sat;
    logic                    r_underrun;

    logic                    w_tick;      // divider at its last count
    logic                    w_tick_fire; // sample consumption this edge
    logic                    w_accept;    // handshake completes this edge
    logic signed [ACC_W-1:0] w_x;         // signed sample, midscale removed
    logic signed [ACC_W-1:0] w_v;         // loop variable fed to quantiser
    logic                    w_b;         // quantiser decision
    logic signed [ACC_W-1:0] w_fb;        // quantiser output, +/-H
    logic signed [ACC_W-1:0] w_err_raw;   // unclamped new error
    logic                    w_clip_hi;
    logic                    w_clip_lo;
    logic signed [ACC_W-1:0] w_e1_next;   // clamped new error

    // ------------------------------------------------------------------------
    // Divider and handshake decode
    // ------------------------------------------------------------------------
    assign w_tick      = (r_cnt == c_CNT_LAST);
    assign w_tick_fire = en & w_tick;

    // Ready is only offered while empty, so an accept can never collide with
    // the tick that empties the buffer.
    assign in_if.in_ready = ~r_buf_full;
    assign w_accept       = in_if.in_valid & ~r_buf_full;

    // ------------------------------------------------------------------------
    // Loop arithmetic
    // ------------------------------------------------------------------------
    // Offset binary to two's complement: subtracting midscale in full width
    assign w_x = $signed({{(ACC_W-IN_W){1'b0}}, r_cur}) - c_HALF;

    generate
        if (ORDER == 2) begin : g_order2
            logic signed [ACC_W-1:0] r_e2;  // error delayed by one more clock

            // Second error tap follows e1 by one enabled clock
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_e2 <= '0;
                end else if (en) begin
                    r_e2 <= r_e1;
                end
            end

            // Error-feedback filter 2*z^-1 - z^-2 gives (1 - z^-1)^2 shaping
            assign w_v = w_x + (r_e1 <<< 1) - r_e2;
        end else if (ORDER == 1) begin : g_order1
            // Single error tap gives first-order (1 - z^-1) shaping
            assign w_v = w_x + r_e1;
        end else begin : g_bad_order
            $error("dsm_dac: ORDER must be 1 or 2");
            assign w_v = '0;
        end
    endgenerate

    // Quantiser: a zero loop variable maps to a one
    assign w_b       = ~w_v[ACC_W-1];
    assign w_fb      = w_b ? c_HALF : -c_HALF;
    assign w_err_raw = w_v - w_fb;

    // Clamp keeps an unstable (overdriven) 2nd-order loop bounded
    assign w_clip_hi = (w_err_raw > c_POS_LIM);
    assign w_clip_lo = (w_err_raw < c_NEG_LIM);

    // Select the clamped error for the next loop state
    always_comb begin
        w_e1_next = w_err_raw;
        if (w_clip_hi) begin
            w_e1_next = c_POS_LIM;
        end else if (w_clip_lo) begin
            w_e1_next = c_NEG_LIM;
        end
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    // Loop state, output bits and divider advance only while enabled; muting
    // zeroes both bridge legs without disturbing the loop history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e1   <= '0;
            r_cnt  <= '0;
            r_outp <= 1'b0;
            r_outn <= 1'b0;
        end else if (en) begin
            r_e1   <= w_e1_next;
            r_cnt  <= w_tick ? '0 : r_cnt + c_CNT_W'(1);
            r_outp <= w_b;
            r_outn <= ~w_b;
        end else begin
            r_outp <= 1'b0;
            r_outn <= 1'b0;
        end
    end

    // Input buffer fill on handshake, drain into the current sample on tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_cur      <= c_MID;
        end else if (r_buf_full) begin
            if (w_tick_fire) begin
                r_cur      <= r_buf;
                r_buf_full <= 1'b0;
            end
        end else if (w_accept) begin
            r_buf      <= in_if.in_data;
            r_buf_full <= 1'b1;
        end
    end

    // Sticky status flags; the clear wins over a same-edge set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat      <= 1'b0;
            r_underrun <= 1'b0;
        end else if (flag_clr) begin
            r_sat      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (en && (w_clip_hi || w_clip_lo)) begin
                r_sat <= 1'b1;
            end
            if (w_tick_fire && !r_buf_full) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign outp     = r_outp;
    assign outn     = r_outn;
    assign sat      = r_sat;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_dsm_dac.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsm_dac
// Description : Directed self-checking bench for dsm_dac. Three instances:
//               u1 ORDER=1/OSR=4, u2 ORDER=2/OSR=6, u3 ORDER=2/OSR=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsm_dac;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en1 = 1'b0, en2 = 1'b0, en3 = 1'b0;
    logic fc1 = 1'b0, fc2 = 1'b0, fc3 = 1'b0;
    logic op1, on1, sat1, ur1;
    logic op2, on2, sat2, ur2;
    logic op3, on3, sat3, ur3;

    int n_tests = 0;
    int n_fail  = 0;

    dsm_dac_if #(.IN_W(16)) if1 ();
    dsm_dac_if #(.IN_W(16)) if2 ();
    dsm_dac_if #(.IN_W(16)) if3 ();

    dsm_dac #(.IN_W(16), .ORDER(1), .OSR(4), .ACC_W(20)) u1 (
        .clk(clk), .rst(rst), .en(en1), .flag_clr(fc1), .in_if(if1),
        .outp(op1), .outn(on1), .sat(sat1), .underrun(ur1)
    );
    dsm_dac #(.IN_W(16), .ORDER(2), .OSR(6), .ACC_W(20)) u2 (
        .clk(clk), .rst(rst), .en(en2), .flag_clr(fc2), .in_if(if2),
        .outp(op2), .outn(on2), .sat(sat2), .underrun(ur2)
    );
    dsm_dac #(.IN_W(16), .ORDER(2), .OSR(8), .ACC_W(20)) u3 (
        .clk(clk), .rst(rst), .en(en3), .flag_clr(fc3), .in_if(if3),
        .outp(op3), .outn(on3), .sat(sat3), .underrun(ur3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] dval(input int i);
        return 16'(32'h1234 + i * 257);
    endfunction

    initial begin
        logic [3:0] pat;
        int ones;
        int n;
        int idx;
        int j;
        logic acc;

        pat = 4'b1001;  // 2nd-order midscale cycle 1,0,0,1 (bit0 first)
        if1.in_valid = 1'b0; if1.in_data = 16'h0000;
        if2.in_valid = 1'b0; if2.in_data = 16'h0000;
        if3.in_valid = 1'b0; if3.in_data = 16'h0000;

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_outp1", op1, 0);
        check("rst_outn1", on1, 0);
        check("rst_ready1", if1.in_ready, 1);
        check("rst_sat1", sat1, 0);
        check("rst_ur1", ur1, 0);
        check("rst_outn2", on2, 0);

        // ---------------- midscale, no samples ----------------
        rst = 1'b0; en1 = 1'b1; en2 = 1'b1;
        ones = 0;
        for (int k = 1; k <= 1024; k++) begin
            tick();
            if (k <= 8) begin
                check("o1_outp", op1, 32'(k % 2));
                check("o1_outn", on1, 32'((k % 2) == 0));
                check("o2_outp", op2, 32'(pat[(k - 1) % 4]));
            end
            if (k == 3) check("o1_ur_pre", ur1, 0);
            if (k == 4) check("o1_ur_tick", ur1, 1);
            ones += int'(op2);
        end
        check("o2_ones1024", ones, 512);
        check("o2_sat_mid", sat2, 0);

        // ---------------- ORDER=1, 0xC000 density ----------------
        if1.in_data = 16'hC000; if1.in_valid = 1'b1; fc1 = 1'b1;
        tick();
        fc1 = 1'b0;
        check("o1_ur_clr", ur1, 0);
        repeat (16) tick();
        ones = 0;
        for (int k = 0; k < 4096; k++) begin
            tick();
            ones += int'(op1);
        end
        check("o1_density_c000", 32'(ones >= 3071 && ones <= 3073), 1);
        check("o1_ur_fed", ur1, 0);
        check("o1_sat_fed", sat1, 0);

        // ---------------- ORDER=2, full-scale overload ----------------
        rst = 1'b1; en1 = 1'b0; if1.in_valid = 1'b0;
        if2.in_data = 16'hFFFF; if2.in_valid = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (!sat2 && n < 64) begin
            tick();
            n++;
        end
        check("o2_sat_set", sat2, 1);
        check("o2_sat_edge", n, 8);
        ones = 0;
        for (int k = 0; k < 1024; k++) begin
            tick();
            ones += int'(op2);
        end
        check("o2_density_ffff", 32'(ones >= 1014), 1);
        fc2 = 1'b1;
        tick();
        fc2 = 1'b0;
        check("o2_sat_clr", sat2, 0);
        n = 0;
        while (!sat2 && n < 2048) begin
            tick();
            n++;
        end
        check("o2_sat_reassert", sat2, 1);

        // ---------------- handshake, OSR=8 ----------------
        rst = 1'b1; if2.in_valid = 1'b0;
        if3.in_data = dval(0); if3.in_valid = 1'b1;
        tick();
        rst = 1'b0; en3 = 1'b1;
        idx = 0;
        for (int k = 1; k <= 80; k++) begin
            acc = if3.in_ready;
            tick();
            check("hs_accept", 32'(acc), 32'((k % 8) == 1));
            if (acc) begin
                idx++;
                if3.in_data = dval(idx);
            end
            check("hs_ready", if3.in_ready, 32'((k % 8) == 0));
            check("hs_cur", u3.r_cur, (k < 8) ? 32'h8000 : 32'(dval(k / 8 - 1)));
        end
        check("hs_count", idx, 10);
        check("hs_underrun", ur3, 0);

        // ---------------- enable gap on ORDER=2 midscale ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0; en2 = 1'b1;
        j = 0;
        for (int k = 1; k <= 26; k++) begin
            if (k == 7)  en2 = 1'b0;
            if (k == 17) en2 = 1'b1;
            tick();
            if (en2) begin
                j++;
                check("gap_outp", op2, 32'(pat[(j - 1) % 4]));
                check("gap_outn", on2, 32'(!pat[(j - 1) % 4]));
            end else begin
                check("gap_outp_mute", op2, 0);
                check("gap_outn_mute", on2, 0);
            end
        end

        // ---------------- reset mid-stream with buffered sample ----------------
        n = 0;
        while (if3.in_ready && n < 16) begin
            tick();
            n++;
        end
        check("mid_ready_pre", if3.in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_outp", op3, 0);
        check("mid_outn", on3, 0);
        check("mid_ready", if3.in_ready, 1);
        check("mid_sat", sat3, 0);
        check("mid_ur", ur3, 0);
        if3.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) check("mid_ur_pre", ur3, 0);
        end
        check("mid_ur_drop", ur3, 1);
        check("mid_cur_drop", u3.r_cur, 32'h8000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsm_dac.md
Name: dsm_dac

Overview:
- Parametrised 1st/2nd-order error-feedback delta-sigma modulator for the stimulator DAC path.
- Converts offset-binary PCM samples into a 1-bit density stream on complementary outputs that drive the output bridge.
- Sample input uses a one-entry valid/ready buffer. A programmable oversampling divider consumes samples.
- Adds mute, overload clamping and underrun reporting.

Parameters:
- IN_W, 16, input sample width (offset binary; midscale = 2^(IN_W-1)).
- ORDER, 2, noise-shaping order; legal values 1 or 2, anything else is a synthesis error.
- OSR, 64, modulator clocks per input sample (>=2).
- ACC_W, IN_W+4, signed width of the loop variable v and the error registers e1/e2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low = freeze loop state and mute outputs.
- in_data  in  IN_W  offset-binary sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  buffer empty, sample accepted when in_valid&in_ready.
- outp  out  1  modulator bit (registered).
- outn  out  1  complement of outp while enabled; 0 when muted.
- sat  out  1  sticky: loop error clamped.
- underrun  out  1  sticky: sample tick found buffer empty.
- flag_clr  in  1  synchronous clear of sat and underrun.

Behaviour:
- Reset (async) values:
  - outp=0, outn=0, in_ready=1, sat=0, underrun=0.
  - e1=e2=0, buffer empty, cur=2^(IN_W-1), tick counter cnt=0.
- Input buffer:
  - in_ready = ~buf_full.
  - A handshake loads buf and sets buf_full. Accepting is independent of en.
- Tick:
  - cnt counts 0..OSR-1 while en=1 and wraps; tick = (cnt==OSR-1).
  - On tick with buf_full: cur<=buf, buf_full<=0. A handshake on the same edge that the buffer empties is impossible, because in_ready was 0.
  - On tick with buffer empty: cur is held and underrun is set.
  - cnt is frozen while en=0.
- Loop (every clk with en=1):
  - x = cur - 2^(IN_W-1) (signed); H = 2^(IN_W-1).
  - ORDER=2: v = x + 2*e1 - e2. ORDER=1: v = x + e1.
  - b = (v >= 0); outp<=b; outn<=~b.
  - en_new = v - (b ? H : -H), clamped to [-2H, 2H-1]. If clamping occurs, set sat.
  - e2<=e1 (ORDER=2 only); e1<=en_new.
  - All arithmetic is signed ACC_W. No intermediate overflow is allowed; ACC_W>=IN_W+4 is required for ORDER=2.
  - The new cur is used from the clock after the tick edge.
- Latency: outp at edge t+1 reflects v formed from the state registered at edge t.
- en=0: outp=outn=0 from the next edge. e1, e2, cur and cnt are held. Resuming continues the same sequence.
- Flags:
  - flag_clr has priority over a set on the same edge.
  - Flags are otherwise sticky until reset.
- Reset mid-operation: all state returns to reset values immediately. A pending buffered sample is discarded.

Test Plan:
- ORDER=1, OSR=4, en=1, no samples (cur midscale) -> outp sequence 1,0,1,0,... from the first enabled edge; outn = ~outp; underrun set at first tick (edge 4).
- ORDER=2, cur midscale -> outp repeats 1,0,0,1 (e1,e2 cycle per hand calc); ones count over 1024 clocks = 512; sat stays 0.
- ORDER=1, IN_W=16, feed 16'hC000 every tick with no underrun -> ones density over 4096 clocks = 3072 ±1; sat=0, underrun=0.
- ORDER=2, feed 16'hFFFF continuously -> sat asserts within 64 clocks; outp density >= 0.99; flag_clr for one cycle drops sat, which re-asserts on a later clamp.
- Handshake, OSR=8: in_valid held high with changing data -> exactly one accept per 8 clocks after the first; in_ready low between accept and tick; no sample lost or duplicated (scoreboard on cur).
- en dropped for 10 cycles mid-stream, then raised -> outp=outn=0 during the gap; resumed outp sequence identical to an uninterrupted run shifted by 10. Assert rst mid-stream -> all outputs at reset values on the same cycle; buffered sample dropped.
